// File: rtl/rf_wb_arbiter_if.sv
// Write-back request bus, register-file write port and decode hazard signals
// shared by the write-back arbiter and its requesters and decode stage.
interface rf_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [5*NUM_REQ-1:0]    req_addr;
  logic [XLEN*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    wr_en;
  logic [4:0]              wr_addr;
  logic [XLEN-1:0]         wr_data;
  logic                    iss_valid;
  logic [4:0]              iss_rd;
  logic [4:0]              id_rs1;
  logic [4:0]              id_rs2;
  logic [4:0]              id_rd;
  logic                    id_valid;
  logic                    stall;
  logic [31:0]             pending;

  modport master (
    output req_valid, req_addr, req_data, iss_valid, iss_rd,
           id_rs1, id_rs2, id_rd, id_valid,
    input  req_ready, wr_en, wr_addr, wr_data, stall, pending
  );

  modport slave (
    input  req_valid, req_addr, req_data, iss_valid, iss_rd,
           id_rs1, id_rs2, id_rd, id_valid,
    output req_ready, wr_en, wr_addr, wr_data, stall, pending
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter onto the single register-file write port,
// plus the pending-write scoreboard that stalls decode on RAW/WAW hazards.
module rf_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  rf_wb_arbiter_if.slave             bus,
  output logic [$clog2(NUM_REQ)-1:0] o_rr_ptr
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W:0] NUM_CNT = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W-1:0]   r_rr_ptr;
  logic               r_wr_en;
  logic [4:0]         r_wr_addr;
  logic [XLEN-1:0]    r_wr_data;
  logic [31:0]        r_pending;

  logic               w_found;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic [PTR_W:0]     w_cand;
  logic [PTR_W:0]     w_inc;
  logic [PTR_W-1:0]   w_next_ptr;
  logic [NUM_REQ-1:0] w_grant;
  logic [4:0]         w_sel_addr;
  logic [XLEN-1:0]    w_sel_data;
  logic [31:0]        w_set;
  logic [31:0]        w_clr;

  // Handshake: a request transfers when req_valid[i] && req_ready[i]; a
  // requester holds valid/addr/data stable until ready. Ready is a pure
  // function of req_valid and r_rr_ptr, never of the write-port state.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_cand >= NUM_CNT) w_cand = w_cand - NUM_CNT;
      if (!w_found && bus.req_valid[w_cand[PTR_W-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    w_grant    = '0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_found && (w_gnt_idx == PTR_W'(i))) begin
        w_grant[i] = 1'b1;
        w_sel_addr = bus.req_addr[5*i +: 5];
        w_sel_data = bus.req_data[XLEN*i +: XLEN];
      end
    end
    w_inc      = {1'b0, w_gnt_idx} + (PTR_W+1)'(1);
    w_next_ptr = (w_inc == NUM_CNT) ? '0 : w_inc[PTR_W-1:0];
  end

  // An x0 grant is consumed but never reaches the register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr  <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_found) begin
      r_rr_ptr <= w_next_ptr;
      r_wr_en  <= (w_sel_addr != 5'd0);
      if (w_sel_addr != 5'd0) begin
        r_wr_addr <= w_sel_addr;
        r_wr_data <= w_sel_data;
      end
    end else begin
      r_wr_en <= 1'b0;
    end
  end

  // Clear lands on the same edge as the register-file write; a same-edge
  // issue to that register re-arms the bit, so set is applied last.
  assign w_set = (bus.iss_valid && (bus.iss_rd != 5'd0)) ? (32'd1 << bus.iss_rd) : 32'd0;
  assign w_clr = r_wr_en ? (32'd1 << r_wr_addr) : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= ((r_pending & ~w_clr) | w_set) & 32'hFFFF_FFFE;
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.pending   = r_pending;
  assign bus.stall     = bus.id_valid &&
                         (r_pending[bus.id_rs1] || r_pending[bus.id_rs2] || r_pending[bus.id_rd]);
  assign o_rr_ptr      = r_rr_ptr;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, hand sequences for reset,
// round-robin and hazard timing, then random traffic against a reference model.
module tb_rf_wb_arbiter;
  localparam int N  = 3;
  localparam int XL = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] rr_ptr;
  int         errors = 0;
  int         checks = 0;

  rf_wb_arbiter_if #(.NUM_REQ(N), .XLEN(XL)) bus();

  rf_wb_arbiter #(.NUM_REQ(N), .XLEN(XL)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .o_rr_ptr (rr_ptr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  rv;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic        iss_v;
    logic [4:0]  iss_rd;
    logic        id_v;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  e_ready;
    logic        e_wr_en;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [31:0] e_pend;
    logic        e_stall;
    logic [1:0]  e_ptr;
  } vec_t;

  vec_t tbl[10];

  // reference model state
  int          m_ptr;
  logic        m_wr_en;
  logic [4:0]  m_wr_addr;
  logic [31:0] m_wr_data;
  logic [31:0] m_pend;
  logic [36:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = 5'd0;
    bus.id_valid  = 1'b0;
    bus.id_rs1    = 5'd0;
    bus.id_rs2    = 5'd0;
    bus.id_rd     = 5'd0;
  endtask

  task automatic m_reset();
    m_ptr     = 0;
    m_wr_en   = 1'b0;
    m_wr_addr = 5'd0;
    m_wr_data = 32'd0;
    m_pend    = 32'd0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) tick();
    rst = 1'b1;
    m_reset();
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.req_valid[i]        = v;
    bus.req_addr[5*i +: 5]  = a;
    bus.req_data[XL*i +: XL] = d;
  endtask

  function automatic int m_grant();
    for (int k = 0; k < N; k++) begin
      if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic m_stall();
    return bus.id_valid && (m_pend[bus.id_rs1] || m_pend[bus.id_rs2] || m_pend[bus.id_rd]);
  endfunction

  function automatic logic [2:0] m_ready();
    int g;
    g = m_grant();
    return (g < 0) ? 3'b000 : 3'(1 << g);
  endfunction

  // advance the model across one clock edge using the inputs now applied
  task automatic m_step();
    int g;
    logic [4:0] a;
    logic old_en;
    logic [4:0] old_addr;
    old_en   = m_wr_en;
    old_addr = m_wr_addr;
    g = m_grant();
    m_wr_en = 1'b0;
    if (g >= 0) begin
      a = bus.req_addr[5*g +: 5];
      m_ptr = (g + 1) % N;
      if (a != 5'd0) begin
        m_wr_en   = 1'b1;
        m_wr_addr = a;
        m_wr_data = bus.req_data[XL*g +: XL];
        exp_q.push_back({a, m_wr_data});
      end
    end
    if (old_en) m_pend[old_addr] = 1'b0;
    if (bus.iss_valid && bus.iss_rd != 5'd0) m_pend[bus.iss_rd] = 1'b1;
  endtask

  task automatic check_model();
    logic [36:0] e;
    chk("rnd_ready",   32'(bus.req_ready), 32'(m_ready()));
    chk("rnd_wr_en",   32'(bus.wr_en),     32'(m_wr_en));
    chk("rnd_wr_addr", 32'(bus.wr_addr),   32'(m_wr_addr));
    chk("rnd_wr_data", bus.wr_data,        m_wr_data);
    chk("rnd_pending", bus.pending,        m_pend);
    chk("rnd_stall",   32'(bus.stall),     32'(m_stall()));
    chk("rnd_rr_ptr",  32'(rr_ptr),        32'(m_ptr));
    if (bus.wr_en) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_write", 32'(bus.wr_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_addr", 32'(bus.wr_addr), 32'(e[36:32]));
        chk("sb_data", bus.wr_data, e[31:0]);
      end
    end
  endtask

  initial begin
    logic [2:0] hold;
    clear_inputs();

    tbl[0] = '{3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b001, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 2'd0};
    tbl[1] = '{3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'h12345678, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b010, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0, 1'b0, 2'd1};
    tbl[2] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9, 5'd0, 5'd0, 3'b000, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0, 1'b0, 2'd2};
    tbl[3] = '{3'b100, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h99, 1'b0, 5'd0, 1'b1, 5'd9, 5'd0, 5'd0, 3'b100, 1'b0, 5'd5, 32'hDEADBEEF, 32'h200, 1'b1, 2'd2};
    tbl[4] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd0, 5'd9, 5'd0, 3'b000, 1'b1, 5'd9, 32'h99, 32'h200, 1'b1, 2'd0};
    tbl[5] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 5'd9, 3'b000, 1'b0, 5'd9, 32'h99, 32'h200, 1'b1, 2'd0};
    tbl[6] = '{3'b001, 5'd9, 5'd0, 5'd0, 32'hAAAA5555, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 5'd9, 3'b001, 1'b0, 5'd9, 32'h99, 32'h200, 1'b1, 2'd0};
    tbl[7] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd9, 5'd0, 5'd0, 3'b000, 1'b1, 5'd9, 32'hAAAA5555, 32'h200, 1'b1, 2'd1};
    tbl[8] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd9, 5'd0, 5'd0, 3'b000, 1'b0, 5'd9, 32'hAAAA5555, 32'h0, 1'b0, 2'd1};
    tbl[9] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd0, 5'd0, 3'b000, 1'b0, 5'd9, 32'hAAAA5555, 32'h0, 1'b0, 2'd1};

    // reset then idle, with decode watching a register
    do_reset();
    bus.id_valid = 1'b1;
    bus.id_rs1   = 5'd5;
    #2;
    chk("rst_wr_en",   32'(bus.wr_en),     32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr),   32'd0);
    chk("rst_wr_data", bus.wr_data,        32'd0);
    chk("rst_ready",   32'(bus.req_ready), 32'd0);
    chk("rst_pending", bus.pending,        32'd0);
    chk("rst_stall",   32'(bus.stall),     32'd0);
    chk("rst_rr_ptr",  32'(rr_ptr),        32'd0);

    // directed table, one record per cycle
    do_reset();
    for (int v = 0; v < 10; v++) begin
      set_req(0, tbl[v].rv[0], tbl[v].a0, tbl[v].d0);
      set_req(1, tbl[v].rv[1], tbl[v].a1, tbl[v].d1);
      set_req(2, tbl[v].rv[2], tbl[v].a2, tbl[v].d2);
      bus.iss_valid = tbl[v].iss_v;
      bus.iss_rd    = tbl[v].iss_rd;
      bus.id_valid  = tbl[v].id_v;
      bus.id_rs1    = tbl[v].rs1;
      bus.id_rs2    = tbl[v].rs2;
      bus.id_rd     = tbl[v].rd;
      #2;
      chk($sformatf("tbl%0d_ready", v),   32'(bus.req_ready), 32'(tbl[v].e_ready));
      chk($sformatf("tbl%0d_wr_en", v),   32'(bus.wr_en),     32'(tbl[v].e_wr_en));
      chk($sformatf("tbl%0d_wr_addr", v), 32'(bus.wr_addr),   32'(tbl[v].e_wa));
      chk($sformatf("tbl%0d_wr_data", v), bus.wr_data,        tbl[v].e_wd);
      chk($sformatf("tbl%0d_pending", v), bus.pending,        tbl[v].e_pend);
      chk($sformatf("tbl%0d_stall", v),   32'(bus.stall),     32'(tbl[v].e_stall));
      chk($sformatf("tbl%0d_rr_ptr", v),  32'(rr_ptr),        32'(tbl[v].e_ptr));
      tick();
    end

    // all three requesters valid for six cycles: grants 0,1,2,0,1,2
    do_reset();
    for (int c = 0; c < 7; c++) begin
      for (int i = 0; i < N; i++) set_req(i, c < 6, 5'(i + 1), 32'hA0 + 32'(i));
      #2;
      chk($sformatf("rr%0d_ready", c), 32'(bus.req_ready), (c < 6) ? (32'd1 << (c % 3)) : 32'd0);
      if (c >= 1) begin
        chk($sformatf("rr%0d_wr_en", c),   32'(bus.wr_en),   32'd1);
        chk($sformatf("rr%0d_wr_addr", c), 32'(bus.wr_addr), 32'((c - 1) % 3 + 1));
        chk($sformatf("rr%0d_wr_data", c), bus.wr_data,      32'hA0 + 32'((c - 1) % 3));
      end
      tick();
    end
    clear_inputs();

    // issue x7, requester 2 writes x7 granted at cycle 4, stall clears at cycle 6
    do_reset();
    for (int c = 0; c < 7; c++) begin
      bus.id_valid  = 1'b1;
      bus.id_rs1    = 5'd7;
      bus.iss_valid = (c == 0);
      bus.iss_rd    = (c == 0) ? 5'd7 : 5'd0;
      set_req(2, c == 4, 5'd7, 32'h7777);
      #2;
      chk($sformatf("haz%0d_stall", c), 32'(bus.stall), (c >= 1 && c <= 5) ? 32'd1 : 32'd0);
      chk($sformatf("haz%0d_ready", c), 32'(bus.req_ready), (c == 4) ? 32'b100 : 32'd0);
      chk($sformatf("haz%0d_wr_en", c), 32'(bus.wr_en), (c == 5) ? 32'd1 : 32'd0);
      tick();
    end
    chk("haz_pending_end", bus.pending, 32'd0);
    clear_inputs();

    // reset asserted while a grant is being written back
    do_reset();
    set_req(0, 1'b1, 5'd3, 32'h33);
    #2;
    chk("mid_ready0", 32'(bus.req_ready), 32'b001);
    tick();
    set_req(0, 1'b1, 5'd4, 32'h44);
    set_req(2, 1'b1, 5'd6, 32'h66);
    #2;
    chk("mid_wr_en_before", 32'(bus.wr_en),     32'd1);
    chk("mid_ready_ptr1",   32'(bus.req_ready), 32'b100);
    rst = 1'b0;
    #1;
    chk("mid_wr_en_dropped", 32'(bus.wr_en),     32'd0);
    chk("mid_rr_ptr_rst",    32'(rr_ptr),        32'd0);
    chk("mid_ready_ptr0",    32'(bus.req_ready), 32'b001);
    tick();
    rst = 1'b1;
    #2;
    chk("mid_after_wr_en", 32'(bus.wr_en),     32'd0);
    chk("mid_after_ready", 32'(bus.req_ready), 32'b001);
    tick();
    chk("mid_regrant_en",   32'(bus.wr_en),   32'd1);
    chk("mid_regrant_addr", 32'(bus.wr_addr), 32'd4);
    clear_inputs();

    // random traffic against the reference model
    do_reset();
    hold = 3'b000;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!hold[i])
          set_req(i, $urandom_range(0, 99) < 55, 5'($urandom_range(0, 15)), $urandom());
      end
      bus.id_valid  = 1'($urandom_range(0, 1));
      bus.id_rs1    = 5'($urandom_range(0, 15));
      bus.id_rs2    = 5'($urandom_range(0, 15));
      bus.id_rd     = 5'($urandom_range(0, 15));
      bus.iss_valid = bus.id_valid && !m_stall() && ($urandom_range(0, 2) != 0);
      bus.iss_rd    = bus.id_rd;
      #2;
      check_model();
      hold = bus.req_valid & ~m_ready();
      m_step();
      tick();
    end
    clear_inputs();
    for (int c = 0; c < 3; c++) begin
      #2;
      check_model();
      m_step();
      tick();
    end
    chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
